// File: rtl/rle_line_encoder_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rle_line_encoder_if : pixel-in / run-word-out handshake bundle            |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
interface rle_line_encoder_if #(
    parameter int WIDTH = 11
);
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_bit;
    logic             pix_sol;
    logic             pix_eol;
    logic             run_valid;
    logic             run_ready;
    logic [WIDTH-1:0] run_len;
    logic             run_last;
    logic             line_err;

    modport master (
        output pix_valid, pix_bit, pix_sol, pix_eol, run_ready,
        input  pix_ready, run_valid, run_len, run_last, line_err
    );

    modport slave (
        input  pix_valid, pix_bit, pix_sol, pix_eol, run_ready,
        output pix_ready, run_valid, run_len, run_last, line_err
    );
endinterface
`default_nettype wire

// File: rtl/rle_line_encoder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | rle_line_encoder : binary mask pixels -> per-line alternating run lengths |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module rle_line_encoder #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    rle_line_encoder_if.slave bus
);
    localparam int               AW         = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] MAX_RUN    = {WIDTH{1'b1}};
    localparam logic [AW:0]      FIFO_SLOTS = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             cur_sym_q, cur_sym_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_word_q, pend_word_d;
    logic             pend_last_q, pend_last_d;
    logic             pend_more_q, pend_more_d;
    logic             push_q, push_d;
    logic [WIDTH-1:0] push_len_q, push_len_d;
    logic             push_last_q, push_last_d;
    logic             line_err_q, line_err_d;

    logic [WIDTH:0]   mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    logic [AW:0]      free_slots;
    logic             accept;
    logic             fifo_nonempty;
    logic             pop;

    // The push register is a word already committed to the FIFO, so it counts as occupied.
    assign free_slots    = FIFO_SLOTS - count_q - {{AW{1'b0}}, push_q};
    assign bus.pix_ready = !RESET && (state_q != PEND) && (free_slots >= (AW+1)'(2));
    assign accept        = bus.pix_valid && bus.pix_ready;

    assign fifo_nonempty = (count_q != '0);
    assign pop           = fifo_nonempty && bus.run_ready;
    assign bus.run_valid = fifo_nonempty;
    assign bus.run_len   = fifo_nonempty ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
    assign bus.run_last  = fifo_nonempty && mem_q[rd_ptr_q][WIDTH];
    assign bus.line_err  = line_err_q;

    always_comb begin
        state_d     = state_q;
        cur_sym_d   = cur_sym_q;
        cnt_d       = cnt_q;
        pend_word_d = pend_word_q;
        pend_last_d = pend_last_q;
        pend_more_d = pend_more_q;
        push_d      = 1'b0;
        push_len_d  = push_len_q;
        push_last_d = push_last_q;
        line_err_d  = 1'b0;

        case (state_q)
            PEND: begin
                if (free_slots != '0) begin
                    push_d      = 1'b1;
                    push_len_d  = pend_word_q;
                    push_last_d = pend_last_q;
                    // Saturation on the eol pixel leaves one more single-pixel word to emit.
                    if (pend_more_q) begin
                        pend_word_d = WIDTH'(1);
                        pend_last_d = 1'b1;
                        pend_more_d = 1'b0;
                    end else begin
                        state_d = pend_last_q ? IDLE : RUN;
                    end
                end
            end
            default: begin
                if (accept && bus.pix_sol) begin
                    line_err_d = (state_q == RUN);
                    cur_sym_d  = bus.pix_bit;
                    cnt_d      = WIDTH'(1);
                    if (!bus.pix_bit) begin
                        if (bus.pix_eol) begin
                            push_d      = 1'b1;
                            push_len_d  = WIDTH'(1);
                            push_last_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        push_d      = 1'b1;
                        push_len_d  = '0;
                        push_last_d = 1'b0;
                        if (bus.pix_eol) begin
                            pend_word_d = WIDTH'(1);
                            pend_last_d = 1'b1;
                            pend_more_d = 1'b0;
                            state_d     = PEND;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end else if (accept && (state_q == RUN)) begin
                    if (bus.pix_bit == cur_sym_q) begin
                        if (cnt_q == MAX_RUN) begin
                            push_d      = 1'b1;
                            push_len_d  = MAX_RUN;
                            push_last_d = 1'b0;
                            cnt_d       = WIDTH'(1);
                            pend_word_d = '0;
                            pend_last_d = 1'b0;
                            pend_more_d = bus.pix_eol;
                            state_d     = PEND;
                        end else if (bus.pix_eol) begin
                            push_d      = 1'b1;
                            push_len_d  = cnt_q + WIDTH'(1);
                            push_last_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end
                    end else begin
                        push_d      = 1'b1;
                        push_len_d  = cnt_q;
                        push_last_d = 1'b0;
                        cur_sym_d   = bus.pix_bit;
                        cnt_d       = WIDTH'(1);
                        if (bus.pix_eol) begin
                            pend_word_d = WIDTH'(1);
                            pend_last_d = 1'b1;
                            pend_more_d = 1'b0;
                            state_d     = PEND;
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_q);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + {{AW{1'b0}}, push_q} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cur_sym_q   <= 1'b0;
            cnt_q       <= '0;
            pend_word_q <= '0;
            pend_last_q <= 1'b0;
            pend_more_q <= 1'b0;
            push_q      <= 1'b0;
            push_len_q  <= '0;
            push_last_q <= 1'b0;
            line_err_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_sym_q   <= cur_sym_d;
            cnt_q       <= cnt_d;
            pend_word_q <= pend_word_d;
            pend_last_q <= pend_last_d;
            pend_more_q <= pend_more_d;
            push_q      <= push_d;
            push_len_q  <= push_len_d;
            push_last_q <= push_last_d;
            line_err_q  <= line_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_q) begin
            mem_q[wr_ptr_q] <= {push_last_q, push_len_q};
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rle_line_encoder.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_rle_line_encoder : directed lines checked against a line-level model   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_rle_line_encoder;
    localparam int W    = 4;
    localparam int D    = 8;
    localparam int MAXR = (1 << W) - 1;

    typedef struct {
        int len;
        bit last;
    } word_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    rle_line_encoder_if #(.WIDTH(W)) bus();

    rle_line_encoder #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int    n_checks     = 0;
    int    n_fail       = 0;
    word_t exp_q[$];
    word_t got_q[$];
    word_t enc_q[$];
    bit    line_q[$];
    bit    in_line      = 1'b0;
    int    committed    = 0;
    bit    exp_err      = 1'b0;
    bit    mon_en       = 1'b0;
    int    n_err_pulses = 0;
    int    n_acc        = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Full encoding of the pixels seen so far on the current line.
    function automatic void encode_line();
        int    runs[$];
        bit    sym;
        int    n;
        int    l;
        word_t w;
        enc_q.delete();
        sym = 1'b0;
        n   = 0;
        foreach (line_q[i]) begin
            if (line_q[i] == sym) n++;
            else begin
                runs.push_back(n);
                sym = ~sym;
                n   = 1;
            end
        end
        runs.push_back(n);
        w.last = 1'b0;
        foreach (runs[r]) begin
            l = runs[r];
            while (l > MAXR) begin
                w.len = MAXR; enc_q.push_back(w);
                w.len = 0;    enc_q.push_back(w);
                l -= MAXR;
            end
            w.len = l;
            enc_q.push_back(w);
        end
    endfunction

    // Every word but the still-growing final run is committed; eol commits all.
    function automatic void model_pixel(input bit b, input bit sol, input bit eol);
        int    ncommit;
        word_t w;
        n_acc++;
        if (sol) begin
            if (in_line) exp_err = 1'b1;
            line_q.delete();
            committed = 0;
            in_line   = 1'b1;
        end
        if (!in_line) return;
        line_q.push_back(b);
        encode_line();
        ncommit = eol ? enc_q.size() : enc_q.size() - 1;
        for (int i = committed; i < ncommit; i++) begin
            w.len  = enc_q[i].len;
            w.last = eol && (i == enc_q.size() - 1);
            exp_q.push_back(w);
        end
        committed = ncommit;
        if (eol) begin
            in_line = 1'b0;
            line_q.delete();
            committed = 0;
        end
    endfunction

    always @(negedge CLK) begin : monitor
        word_t w;
        if (mon_en) begin
            chk("line_err", bus.line_err, exp_err);
            if (bus.line_err) n_err_pulses++;
            if (bus.run_valid) begin
                chk("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    chk("run_len", int'(bus.run_len), exp_q[0].len);
                    chk("run_last", bus.run_last, exp_q[0].last);
                end
            end
            exp_err = 1'b0;
            if (RESET) begin
                exp_q.delete();
                line_q.delete();
                in_line   = 1'b0;
                committed = 0;
            end else begin
                if (bus.run_valid && bus.run_ready) begin
                    w.len  = int'(bus.run_len);
                    w.last = bus.run_last;
                    got_q.push_back(w);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
                if (bus.pix_valid && bus.pix_ready)
                    model_pixel(bus.pix_bit, bus.pix_sol, bus.pix_eol);
            end
        end
    end

    task automatic send_px(input bit b, input bit sol, input bit eol);
        int t;
        bit acc;
        bus.pix_valid = 1'b1;
        bus.pix_bit   = b;
        bus.pix_sol   = sol;
        bus.pix_eol   = eol;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 300) begin
            @(negedge CLK);
            acc = bus.pix_ready;
            @(posedge CLK); #1;
            t++;
        end
        if (!acc) chk("pix_accept_timeout", 0, 1);
        bus.pix_valid = 1'b0;
        bus.pix_sol   = 1'b0;
        bus.pix_eol   = 1'b0;
    endtask

    // Pixel i of the line is bits[i]; sol on the first, optional eol on the last.
    task automatic send_line(input logic [31:0] bits, input int n, input bit eol_end);
        for (int i = 0; i < n; i++) send_px(bits[i], i == 0, eol_end && (i == n - 1));
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        bus.run_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.run_valid) && t < 500) begin
            @(posedge CLK); #1;
            t++;
        end
        chk({name, "_drain_done"}, t < 500, 1);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic check_log(input string name, input int lens[16], input int n, input int last_idx);
        chk({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) begin
                chk($sformatf("%s_len%0d", name, i), got_q[i].len, lens[i]);
                chk($sformatf("%s_last%0d", name, i), got_q[i].last, i == last_idx);
            end
        end
        got_q.delete();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int el[16];
        int acc0;
        int e0;
        bus.pix_valid = 1'b0;
        bus.pix_bit   = 1'b0;
        bus.pix_sol   = 1'b0;
        bus.pix_eol   = 1'b0;
        bus.run_ready = 1'b0;

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_pix_ready_low", bus.pix_ready, 0);
        @(posedge CLK); #1;
        RESET  = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK);
        chk("post_reset_pix_ready", bus.pix_ready, 1);
        chk("post_reset_run_valid", bus.run_valid, 0);
        chk("post_reset_run_len", int'(bus.run_len), 0);
        chk("post_reset_run_last", bus.run_last, 0);
        chk("post_reset_line_err", bus.line_err, 0);
        @(posedge CLK); #1;

        // Pixels outside a line are dropped, then 0,0,0,1,1,0.
        bus.run_ready = 1'b1;
        send_px(1'b1, 1'b0, 1'b0);
        send_px(1'b0, 1'b0, 1'b1);
        send_line(32'h18, 6, 1'b1);
        drain("basic");
        el = '{0:3, 1:2, 2:1, default:0};
        check_log("basic", el, 3, 2);

        send_line(32'h3, 3, 1'b1);
        drain("lead_one");
        el = '{0:0, 1:2, 2:1, default:0};
        check_log("lead_one", el, 3, 2);

        send_line(32'h1, 1, 1'b1);
        drain("single_one");
        el = '{0:0, 1:1, default:0};
        check_log("single_one", el, 2, 1);

        send_line(32'h0, 1, 1'b1);
        drain("single_zero");
        el = '{0:1, default:0};
        check_log("single_zero", el, 1, 0);

        send_line(32'h0, 17, 1'b1);
        drain("sat_zeros");
        el = '{0:15, 1:0, 2:2, default:0};
        check_log("sat_zeros", el, 3, 2);

        send_line(32'hFFFF, 16, 1'b1);
        drain("sat_eol");
        el = '{0:0, 1:15, 2:0, 3:1, default:0};
        check_log("sat_eol", el, 4, 3);

        // Consumer stalled across a long alternating line.
        bus.run_ready = 1'b0;
        acc0 = n_acc;
        fork
            send_line(32'hAAA, 12, 1'b1);
            begin
                repeat (40) @(posedge CLK);
                @(negedge CLK);
                chk("bp_accepted", n_acc - acc0, 8);
                chk("bp_pix_ready", bus.pix_ready, 0);
                chk("bp_words_waiting", exp_q.size(), 7);
                @(posedge CLK); #1;
                for (int i = 0; i < 60; i++) begin
                    bus.run_ready = 1'($urandom_range(0, 1));
                    @(posedge CLK); #1;
                end
                bus.run_ready = 1'b1;
            end
        join
        drain("backpressure");
        el = '{default:1};
        check_log("backpressure", el, 12, 11);

        // Premature sol aborts the 0,1 line; new line is 1,0,0.
        e0 = n_err_pulses;
        send_line(32'h2, 2, 1'b0);
        send_line(32'h1, 3, 1'b1);
        drain("abort");
        el = '{0:1, 1:0, 2:1, 3:2, default:0};
        check_log("abort", el, 4, 3);
        chk("abort_err_pulses", n_err_pulses - e0, 1);

        // Reset with three words waiting in the FIFO.
        bus.run_ready = 1'b0;
        send_line(32'hA, 4, 1'b0);
        repeat (4) @(posedge CLK);
        #1;
        chk("rst_mid_words_queued", exp_q.size(), 3);
        chk("rst_mid_run_valid_before", bus.run_valid, 1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk("rst_mid_run_valid_after", bus.run_valid, 0);
        chk("rst_mid_pix_ready_after", bus.pix_ready, 1);
        @(posedge CLK); #1;
        got_q.delete();
        bus.run_ready = 1'b1;
        send_line(32'h1, 2, 1'b1);
        drain("after_reset");
        el = '{0:0, 1:1, 2:1, default:0};
        check_log("after_reset", el, 3, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
